// File: rtl/cordic_pkg.sv
// Shared constants, payload type and fixed-point helpers for the CORDIC phase generator.
// Angles are signed W:10 fixed point (radians * 1024).
package cordic_pkg;

    localparam int unsigned FXP_FRAC     = 10;
    localparam int unsigned W            = 12;
    localparam int unsigned ACC_W        = 14;
    localparam int unsigned PIPE_LATENCY = 15;

    localparam logic signed [ACC_W-1:0] PI_FXP          = 14'sd3217;
    localparam logic signed [ACC_W-1:0] NEG_PI_FXP      = -14'sd3217;
    localparam logic signed [ACC_W-1:0] HALF_PI_FXP     = 14'sd1608;
    localparam logic signed [ACC_W-1:0] NEG_HALF_PI_FXP = -14'sd1608;
    localparam logic signed [ACC_W-1:0] TWO_PI_FXP      = 14'sd6434;

    // Folded angle plus the flag telling the back end to negate cos.
    typedef struct packed {
        logic                neg;
        logic signed [W-1:0] angle;
    } fold_t;

    // Bring a phase sum back into [-pi, pi); one correction suffices since |freq| < pi.
    function automatic logic signed [ACC_W-1:0] wrap(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = s;
        if (s >= PI_FXP) begin
            r = s - TWO_PI_FXP;
        end else if (s < NEG_PI_FXP) begin
            r = s + TWO_PI_FXP;
        end
        return r;
    endfunction

    // Reflect the outer half-circle into [-pi/2, pi/2]; sin is preserved, cos flips sign.
    function automatic fold_t fold(input logic signed [ACC_W-1:0] p);
        logic signed [ACC_W-1:0] r;
        fold_t                   f;
        r     = p;
        f.neg = 1'b0;
        if (p > HALF_PI_FXP) begin
            r     = PI_FXP - p;
            f.neg = 1'b1;
        end else if (p < NEG_HALF_PI_FXP) begin
            r     = NEG_PI_FXP - p;
            f.neg = 1'b1;
        end
        f.angle = W'(r);
        return f;
    endfunction

endpackage

// File: rtl/cordic_flag_delay.sv
// Clock-enabled shift register used to align side-band flags with the CORDIC pipeline.
// Ports: clk, rst_n (async active-low), ce_i (shift enable), d_i (flag in), q_o (flag DEPTH ce cycles later).
module cordic_flag_delay #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][WIDTH-1:0] sr_d;

    // Shift toward the tail only on enabled cycles.
    always_comb begin
        sr_d = sr_q;
        if (ce_i) begin
            sr_d = {sr_q[DEPTH-2:0], d_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO front end: accumulates a signed frequency word, wraps the phase into [-pi, pi),
// folds it into [-pi/2, pi/2] for the CORDIC angle input and delays the cos-negate flag
// to line up with the pipeline outputs.
// Ports: clock, reset_n (async active-low), ce, freq_in/freq_load (frequency word),
//        phase_clr (zero the accumulator), angle_out/angle_valid (folded angle),
//        cos_neg_dly (cos-negate flag, PIPE_LATENCY ce cycles behind angle_out).
module cordic_phase_gen
    import cordic_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ce,
    input  logic signed [W-1:0] freq_in,
    input  logic                freq_load,
    input  logic                phase_clr,
    output logic signed [W-1:0] angle_out,
    output logic                angle_valid,
    output logic                cos_neg_dly
);

    logic signed [ACC_W-1:0] phase_q, phase_d;
    logic signed [ACC_W-1:0] freq_q,  freq_d;
    logic signed [W-1:0]     angle_q, angle_d;
    logic                    neg_q,   neg_d;
    logic                    valid_q, valid_d;
    fold_t                   fold_c;

    // Output is taken from the pre-update phase, so the first sample after a clear is 0.
    always_comb begin
        phase_d = phase_q;
        freq_d  = freq_q;
        angle_d = angle_q;
        neg_d   = neg_q;
        valid_d = valid_q;
        fold_c  = fold(phase_q);
        if (ce) begin
            angle_d = fold_c.angle;
            neg_d   = fold_c.neg;
            valid_d = 1'b1;
            phase_d = phase_clr ? '0 : wrap(phase_q + freq_q);
            if (freq_load) begin
                freq_d = ACC_W'(freq_in);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            freq_q  <= '0;
            angle_q <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            freq_q  <= freq_d;
            angle_q <= angle_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
        end
    end

    cordic_flag_delay #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (1)
    ) u_neg_dly (
        .clk   (clock),
        .rst_n (reset_n),
        .ce_i  (ce),
        .d_i   (neg_q),
        .q_o   (cos_neg_dly)
    );

    assign angle_out   = angle_q;
    assign angle_valid = valid_q;

endmodule
